button_gesture: RTL and testbench
=================================

// Module: button_gesture
// PURPOSE
//  Consumes the debounced level (pressed) and the one-cycle press strobe (pulse) from the
//  button debouncer; classifies each gesture as short, long or double press.
//  Emits one-cycle event strobes to the application control logic.
//  Sits directly downstream of the debouncer, in the same clk domain.
// PARAMETERS
//  CNT_W        16   width of internal tick counter; all *_TICKS must be < 2**CNT_W
//  LONG_TICKS   1000 cycles pressed (from pulse) before long_press fires; >= 2
//  DOUBLE_TICKS 300  cycles after release within which a 2nd pulse counts as double; >= 2
//  REPEAT_TICKS 200  auto-repeat period while held (only with BUTTON_REPEAT_EN); >= 2
// PORTS
//  clk          in  1  system clock, all logic on posedge
//  rst          in  1  asynchronous reset, active-high
//  pressed      in  1  debounced, synchronised button level from the debouncer
//  pulse        in  1  one-cycle strobe at press onset from the debouncer
//  short_press  out 1  one-cycle strobe: single short press confirmed
//  long_press   out 1  one-cycle strobe: press held LONG_TICKS
//  double_press out 1  one-cycle strobe: second press within DOUBLE_TICKS of release
//  held         out 1  level: high while in LONG state
//  repeat_press out 1  one-cycle strobe (tied 0 without BUTTON_REPEAT_EN)
// BEHAVIOUR
//  - rst asserted (any time, incl. mid-gesture): state=IDLE, cnt=0, all outputs 0;
//    no event emitted for an interrupted gesture. First gesture is recognised on the
//    first pulse after rst deasserts.
//  - All outputs registered; strobe asserts in the cycle after the deciding input is sampled.
//  - At most one of short/long/double/repeat strobes is high in any cycle.
//  - States / transitions (evaluated each posedge, first match wins):
//    IDLE : pulse -> DOWN1, cnt=0.
//    DOWN1: !pressed -> WAIT2, cnt=0
//           | cnt==LONG_TICKS-1 -> LONG, long_press=1, cnt=0 | else cnt++.
//    WAIT2: pulse -> DOWN2, double_press=1
//           | cnt==DOUBLE_TICKS-1 -> IDLE, short_press=1 | else cnt++.
//           A pulse coinciding with timeout counts as a double press; no short_press.
//    DOWN2: !pressed -> IDLE. Second press never produces long_press.
//    LONG : !pressed -> IDLE (no further event); held=1 while in LONG.
//  - pulse while in DOWN1/DOWN2/LONG is ignored (debouncer glitch guard).
//  - pressed low in the same cycle as pulse in IDLE: enter DOWN1; release is seen next cycle.
//  - Counter compares by equality; it never wraps, because every state resets it on exit.
//  - short_press latency = release + DOUBLE_TICKS cycles; expected by UI layer.
// CONFIGURATION
//  BUTTON_REPEAT_EN defined:
//    in LONG, cnt counts; cnt==REPEAT_TICKS-1 -> repeat_press=1, cnt=0.
//    First repeat fires REPEAT_TICKS cycles after long_press; release cancels cleanly.
//  BUTTON_REPEAT_EN undefined: repeat_press constant 0; no repeat counter logic.
// TESTING  (bench params: LONG_TICKS=8, DOUBLE_TICKS=4, REPEAT_TICKS=3)
//  1. rst high 3 cycles, inputs toggling -> all outputs 0 throughout; idle after release.
//  2. pulse+pressed 3 cycles, release, idle 10 -> short_press exactly once,
//     4 cycles after release sampled; no other strobe.
//  3. press 3, release 2, pulse+press 2, release -> double_press once;
//     short_press never asserted.
//  4. press held 20 cycles -> long_press once, 8 cycles after pulse; held=1 until
//     cycle after release; no short_press.
//     With BUTTON_REPEAT_EN: repeat_press at +3,+6,+9 after long_press.
//  5. release, then pulse in exact timeout cycle of WAIT2 -> double_press=1, short_press=0.
//  6. press, assert rst at cycle 5 of DOWN1, release during rst -> no events;
//     next full short gesture yields a normal short_press.

Source files
------------

// File: rtl/button_gesture.sv
// Classifies debounced button gestures into short / long / double press strobes.
// Define BUTTON_REPEAT_EN to add auto-repeat strobes while the button is held long.
module button_gesture #(
  parameter int CNT_W        = 16,
  parameter int LONG_TICKS   = 1000,
  parameter int DOUBLE_TICKS = 300,
  parameter int REPEAT_TICKS = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic pressed,
  input  logic pulse,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic held,
  output logic repeat_press
);

  typedef enum logic [2:0] {IDLE, DOWN1, WAIT2, DOWN2, LONG} state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DOUBLE_TICKS - 1);

  if (CNT_W < 2 || LONG_TICKS < 2 || DOUBLE_TICKS < 2 || REPEAT_TICKS < 2 ||
      LONG_TICKS >= 2**CNT_W || DOUBLE_TICKS >= 2**CNT_W || REPEAT_TICKS >= 2**CNT_W)
  begin : g_bad_param
    $error("button_gesture: tick parameters out of range");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;

`ifdef BUTTON_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_TICKS - 1);
`else
  assign repeat_press = 1'b0;
`endif

  // Counter is cleared on every state exit, so equality compares never miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      held         <= 1'b0;
`ifdef BUTTON_REPEAT_EN
      repeat_press <= 1'b0;
`endif
    end else begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
`ifdef BUTTON_REPEAT_EN
      repeat_press <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pulse) begin
            state <= DOWN1;
            cnt   <= '0;
          end
        end
        DOWN1: begin
          if (!pressed) begin
            state <= WAIT2;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state      <= LONG;
            long_press <= 1'b1;
            held       <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT2: begin
          // A pulse on the timeout cycle still wins as a double press.
          if (pulse) begin
            state        <= DOWN2;
            double_press <= 1'b1;
            cnt          <= '0;
          end else if (cnt == DBL_LAST) begin
            state       <= IDLE;
            short_press <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DOWN2: begin
          if (!pressed) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        LONG: begin
          if (!pressed) begin
            state <= IDLE;
            held  <= 1'b0;
            cnt   <= '0;
          end
`ifdef BUTTON_REPEAT_EN
          else if (cnt == REP_LAST) begin
            repeat_press <= 1'b1;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        default: begin
          state <= IDLE;
          held  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_gesture.sv
// Vector-table bench for button_gesture with an expected-output queue per cycle.
module tb_button_gesture;

  localparam int LT = 8, DT = 4, RT = 3;
`ifdef BUTTON_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, pressed = 1'b0, pulse = 1'b0;
  logic short_press, long_press, double_press, held, repeat_press;

  button_gesture #(.CNT_W(16), .LONG_TICKS(LT), .DOUBLE_TICKS(DT), .REPEAT_TICKS(RT)) dut (
    .clk(clk), .rst(rst), .pressed(pressed), .pulse(pulse),
    .short_press(short_press), .long_press(long_press), .double_press(double_press),
    .held(held), .repeat_press(repeat_press)
  );

  always #5 clk = ~clk;

  // exp bits: {short, long, double, held, repeat}
  typedef struct {
    int         tid;
    logic       r;
    logic       p;
    logic       pr;
    logic [4:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] sb[$];
  int         n_chk = 0, n_fail = 0;

  function automatic logic [4:0] outs();
    return {short_press, long_press, double_press, held, repeat_press};
  endfunction

  task automatic add(input int tid, input logic r, input logic p, input logic pr,
                     input logic [4:0] exp, input int reps = 1);
    vec_t v;
    v.tid = tid; v.r = r; v.p = p; v.pr = pr; v.exp = exp;
    for (int i = 0; i < reps; i++) vecs.push_back(v);
  endtask

  task automatic check(input int tid, input int row, input logic [4:0] exp);
    logic [4:0] got;
    got = outs();
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL t%0d row%0d outputs{sh,lg,db,hd,rp} got %b expected %b", tid, row, got, exp);
    end
  endtask

  // Drive one cycle; the expected post-edge outputs go into the scoreboard first.
  task automatic step(input int tid, input int row, input logic r, input logic p,
                      input logic pr, input logic [4:0] exp);
    logic [4:0] e;
    rst = r; pulse = p; pressed = pr;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(tid, row, e);
  endtask

  initial begin
    // Reset state at time zero
    #1;
    check(0, 0, 5'b00000);

    // 1: reset held with toggling inputs, then idle
    add(1, 1, 1, 1, 5'b00000);
    add(1, 1, 0, 0, 5'b00000);
    add(1, 1, 1, 1, 5'b00000);
    add(1, 0, 0, 0, 5'b00000, 2);
    // 2: short press, fires 4 edges after the release edge
    add(2, 0, 1, 1, 5'b00000);
    add(2, 0, 0, 1, 5'b00000, 2);
    add(2, 0, 0, 0, 5'b00000, 4);
    add(2, 0, 0, 0, 5'b10000);
    add(2, 0, 0, 0, 5'b00000, 6);
    // 3: double press, no short afterwards
    add(3, 0, 1, 1, 5'b00000);
    add(3, 0, 0, 1, 5'b00000, 2);
    add(3, 0, 0, 0, 5'b00000, 2);
    add(3, 0, 1, 1, 5'b00100);
    add(3, 0, 0, 1, 5'b00000);
    add(3, 0, 0, 0, 5'b00000, 8);
    // 4: long press 8 edges after pulse edge, held until release, repeats at +3/+6/+9
    add(4, 0, 1, 1, 5'b00000);
    add(4, 0, 0, 1, 5'b00000, 7);
    add(4, 0, 0, 1, 5'b01010);
    for (int k = 1; k <= 11; k++)
      add(4, 0, 0, 1, {3'b000, 1'b1, REP && (k % 3 == 0)});
    add(4, 0, 0, 0, 5'b00000);
    add(4, 0, 0, 0, 5'b00000, 6);
    // 5: second pulse on the exact WAIT2 timeout cycle
    add(5, 0, 1, 1, 5'b00000);
    add(5, 0, 0, 1, 5'b00000);
    add(5, 0, 0, 0, 5'b00000, 4);
    add(5, 0, 1, 1, 5'b00100);
    add(5, 0, 0, 1, 5'b00000);
    add(5, 0, 0, 0, 5'b00000, 6);
    // 1b: press and release in the pulse cycle itself (release seen one edge later)
    add(7, 0, 1, 0, 5'b00000);
    add(7, 0, 0, 0, 5'b00000, 4);
    add(7, 0, 0, 0, 5'b10000);
    add(7, 0, 0, 0, 5'b00000, 2);

    foreach (vecs[i]) step(vecs[i].tid, i, vecs[i].r, vecs[i].p, vecs[i].pr, vecs[i].exp);

    // 6: reset in DOWN1 (cnt=4), release during reset -> no events, then normal short
    step(6, 0, 0, 1, 1, 5'b00000);
    for (int i = 1; i <= 4; i++) step(6, i, 0, 0, 1, 5'b00000);
    step(6, 5, 1, 0, 1, 5'b00000);
    step(6, 6, 1, 0, 0, 5'b00000);
    step(6, 7, 1, 0, 0, 5'b00000);
    for (int i = 8; i < 22; i++) step(6, i, 0, 0, 0, 5'b00000);
    step(6, 22, 0, 1, 1, 5'b00000);
    step(6, 23, 0, 0, 1, 5'b00000);
    for (int i = 24; i < 28; i++) step(6, i, 0, 0, 0, 5'b00000);
    step(6, 28, 0, 0, 0, 5'b10000);
    step(6, 29, 0, 0, 0, 5'b00000);

    // 8: async reset mid-cycle while held drops held without a clock edge
    step(8, 0, 0, 1, 1, 5'b00000);
    for (int i = 1; i < 8; i++) step(8, i, 0, 0, 1, 5'b00000);
    step(8, 8, 0, 0, 1, 5'b01010);
    step(8, 9, 0, 0, 1, {4'b0001, 1'b0});
    #2 rst = 1'b1;
    #1 check(8, 10, 5'b00000);
    step(8, 11, 0, 0, 0, 5'b00000);
    for (int i = 12; i < 24; i++) step(8, i, 0, 0, 0, 5'b00000);

    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard leftover entries got %0d expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Strobes are mutually exclusive every cycle.
  always @(negedge clk) begin
    if ($countones({short_press, long_press, double_press, repeat_press}) > 1) begin
      n_fail++;
      $display("FAIL strobe_onehot got %b expected at most one set",
               {short_press, long_press, double_press, repeat_press});
    end
  end

endmodule
